// File: rtl/sc_mips_core.sv
//------------------------------------------------------------------------------
// sc_mips_core
//
// Single-cycle 32-bit MIPS subset CPU for the FPGA board image. Each rising
// edge of sysclk retires exactly one instruction.
//
// Included on chip:
//   - an instruction ROM, loaded from IMEM_INIT (word 0 in the LSBs)
//   - a data RAM
//   - memory-mapped board I/O (switches, LEDs and a 16-bit display register)
//
// Supported instructions:
//   R-type : addu subu and or slt sll jr
//   I-type : addiu andi ori lui lw sw beq bne
//   J-type : j jal
//   Any other encoding retires as a NOP: only PC+4 takes effect.
//
// Memory map (word aligned, addr[1:0] ignored):
//   0x0000_0000-0x0000_00FF : data RAM (combinational read, write on the edge)
//   0x4000_000C             : LED register (read/write)
//   0x4000_0010             : switches (read only)
//   0x4000_0014             : display register (read/write)
//   anything else           : reads 0, writes are dropped
//
// Build option:
//   SEG_DECODE_EN defined   : digi_out1..4 hex-decode disp_reg nibbles 0..3
//                             (active-low {g,f,e,d,c,b,a})
//   SEG_DECODE_EN undefined : digi_out1..4 are held at 7'h7F (all segments off)
//
// Parameters:
//   IMEM_WORDS : ROM depth in words; fetches past it return 0 (a NOP)
//   DMEM_WORDS : RAM depth in words; the RAM index is addr[7:2]
//   IMEM_INIT  : ROM contents; the default is the switch->LED/display boot loop
//
// Ports:
//   sysclk    in  1 : system clock, rising edge
//   Reset_n   in  1 : asynchronous active-low reset
//   switch    in  8 : board switches
//   led       out 8 : board LEDs (registered)
//   digi_out1 out 7 : 7-seg digit 0 (least significant nibble)
//   digi_out2 out 7 : 7-seg digit 1
//   digi_out3 out 7 : 7-seg digit 2
//   digi_out4 out 7 : 7-seg digit 3 (most significant nibble)
//------------------------------------------------------------------------------
module sc_mips_core #(
   parameter int IMEM_WORDS = 64,
   parameter int DMEM_WORDS = 64,
   parameter logic [IMEM_WORDS*32-1:0] IMEM_INIT = {
      {((IMEM_WORDS-6)*32){1'b0}},
      32'h0800_0001,   // 5: j 1
      32'hAD0A_0014,   // 4: sw  $10,0x14($8)
      32'h0009_5040,   // 3: sll $10,$9,1
      32'hAD09_000C,   // 2: sw  $9,0x0C($8)
      32'h8D09_0010,   // 1: lw  $9,0x10($8)
      32'h3C08_4000    // 0: lui $8,0x4000
   }
) (
   input  logic       sysclk,
   input  logic       Reset_n,
   input  logic [7:0] switch,
   output logic [7:0] led,
   output logic [6:0] digi_out1,
   output logic [6:0] digi_out2,
   output logic [6:0] digi_out3,
   output logic [6:0] digi_out4
);

   // Opcodes
   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   // R-type function codes
   localparam logic [5:0] FN_SLL  = 6'h00;
   localparam logic [5:0] FN_JR   = 6'h08;
   localparam logic [5:0] FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUBU = 6'h23;
   localparam logic [5:0] FN_AND  = 6'h24;
   localparam logic [5:0] FN_OR   = 6'h25;
   localparam logic [5:0] FN_SLT  = 6'h2A;

   // I/O register word addresses (byte address >> 2)
   localparam logic [29:0] LED_WADDR  = 30'h1000_0003;
   localparam logic [29:0] SW_WADDR   = 30'h1000_0004;
   localparam logic [29:0] DISP_WADDR = 30'h1000_0005;
   localparam logic [29:0] IMEM_LIMIT = 30'(IMEM_WORDS);

   logic [31:0] r_pc;
   logic [31:0] r_regs [0:31];
   logic [31:0] r_ram  [0:DMEM_WORDS-1];
   logic [7:0]  r_led;
   logic [15:0] r_disp;

   logic [31:0] w_instr;
   logic [5:0]  w_op;
   logic [4:0]  w_rs;
   logic [4:0]  w_rt;
   logic [4:0]  w_rd;
   logic [4:0]  w_shamt;
   logic [5:0]  w_funct;
   logic [15:0] w_imm;
   logic [25:0] w_target;
   logic [31:0] w_rs_val;
   logic [31:0] w_rt_val;
   logic [31:0] w_sext;
   logic [31:0] w_zext;
   logic [31:0] w_pc4;
   logic [31:0] w_br_target;
   logic [31:0] w_addr;
   logic        w_sel_ram;
   logic        w_sel_led;
   logic        w_sel_sw;
   logic        w_sel_disp;
   logic [31:0] w_load_data;
   logic        w_reg_we;
   logic [4:0]  w_wa;
   logic [31:0] w_wd;
   logic        w_mem_we;
   logic [31:0] w_next_pc;
   logic        w_unused_addr_lsb;

   // ROM fetch; anything past the end of the image reads as a NOP
   assign w_instr = (r_pc[31:2] < IMEM_LIMIT) ? IMEM_INIT[{r_pc[7:2], 5'b00000} +: 32] : 32'h0000_0000;

   assign w_op     = w_instr[31:26];
   assign w_rs     = w_instr[25:21];
   assign w_rt     = w_instr[20:16];
   assign w_rd     = w_instr[15:11];
   assign w_shamt  = w_instr[10:6];
   assign w_funct  = w_instr[5:0];
   assign w_imm    = w_instr[15:0];
   assign w_target = w_instr[25:0];

   // $0 is never written, but force the read to zero so it cannot leak
   assign w_rs_val = (w_rs == 5'd0) ? 32'h0000_0000 : r_regs[w_rs];
   assign w_rt_val = (w_rt == 5'd0) ? 32'h0000_0000 : r_regs[w_rt];

   assign w_sext      = {{16{w_imm[15]}}, w_imm};
   assign w_zext      = {16'h0000, w_imm};
   assign w_pc4       = r_pc + 32'd4;
   assign w_br_target = w_pc4 + (w_sext << 2);
   assign w_addr      = w_rs_val + w_sext;

   assign w_sel_ram         = (w_addr[31:8] == 24'h00_0000);
   assign w_sel_led         = (w_addr[31:2] == LED_WADDR);
   assign w_sel_sw          = (w_addr[31:2] == SW_WADDR);
   assign w_sel_disp        = (w_addr[31:2] == DISP_WADDR);
   assign w_unused_addr_lsb = ^w_addr[1:0];

   // Load data mux across RAM and the I/O registers
   always_comb begin
      w_load_data = 32'h0000_0000;
      if (w_sel_ram) begin
         w_load_data = r_ram[w_addr[7:2]];
      end else if (w_sel_led) begin
         w_load_data = {24'h00_0000, r_led};
      end else if (w_sel_sw) begin
         w_load_data = {24'h00_0000, switch};
      end else if (w_sel_disp) begin
         w_load_data = {16'h0000, r_disp};
      end else begin
         w_load_data = 32'h0000_0000;
      end
   end

   // Instruction decode / execute: register write, store enable and next PC
   always_comb begin
      w_reg_we  = 1'b0;
      w_wa      = w_rt;
      w_wd      = 32'h0000_0000;
      w_mem_we  = 1'b0;
      w_next_pc = w_pc4;
      case (w_op)
         OP_RTYPE: begin
            w_wa = w_rd;
            case (w_funct)
               FN_SLL:  begin w_reg_we = 1'b1; w_wd = w_rt_val << w_shamt; end
               FN_JR:   w_next_pc = w_rs_val;
               FN_ADDU: begin w_reg_we = 1'b1; w_wd = w_rs_val + w_rt_val; end
               FN_SUBU: begin w_reg_we = 1'b1; w_wd = w_rs_val - w_rt_val; end
               FN_AND:  begin w_reg_we = 1'b1; w_wd = w_rs_val & w_rt_val; end
               FN_OR:   begin w_reg_we = 1'b1; w_wd = w_rs_val | w_rt_val; end
               FN_SLT:  begin
                  w_reg_we = 1'b1;
                  w_wd     = ($signed(w_rs_val) < $signed(w_rt_val)) ? 32'd1 : 32'd0;
               end
               default: w_reg_we = 1'b0;
            endcase
         end
         OP_J:     w_next_pc = {w_pc4[31:28], w_target, 2'b00};
         OP_JAL:   begin
            w_reg_we  = 1'b1;
            w_wa      = 5'd31;
            w_wd      = w_pc4;
            w_next_pc = {w_pc4[31:28], w_target, 2'b00};
         end
         OP_BEQ:   w_next_pc = (w_rs_val == w_rt_val) ? w_br_target : w_pc4;
         OP_BNE:   w_next_pc = (w_rs_val != w_rt_val) ? w_br_target : w_pc4;
         OP_ADDIU: begin w_reg_we = 1'b1; w_wd = w_rs_val + w_sext; end
         OP_ANDI:  begin w_reg_we = 1'b1; w_wd = w_rs_val & w_zext; end
         OP_ORI:   begin w_reg_we = 1'b1; w_wd = w_rs_val | w_zext; end
         OP_LUI:   begin w_reg_we = 1'b1; w_wd = {w_imm, 16'h0000}; end
         OP_LW:    begin w_reg_we = 1'b1; w_wd = w_load_data; end
         OP_SW:    w_mem_we = 1'b1;
         default:  w_reg_we = 1'b0;
      endcase
   end

   // Program counter
   always_ff @(posedge sysclk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_pc <= 32'h0000_0000;
      end else begin
         r_pc <= w_next_pc;
      end
   end

   // Register file write port; writes to $0 are dropped
   always_ff @(posedge sysclk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < 32; i++) begin
            r_regs[i] <= 32'h0000_0000;
         end
      end else if (w_reg_we && (w_wa != 5'd0)) begin
         r_regs[w_wa] <= w_wd;
      end
   end

   // Data RAM write port
   always_ff @(posedge sysclk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < DMEM_WORDS; i++) begin
            r_ram[i] <= 32'h0000_0000;
         end
      end else if (w_mem_we && w_sel_ram) begin
         r_ram[w_addr[7:2]] <= w_rt_val;
      end
   end

   // Memory-mapped LED and display registers
   always_ff @(posedge sysclk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_led  <= 8'h00;
         r_disp <= 16'h0000;
      end else if (w_mem_we) begin
         if (w_sel_led) begin
            r_led <= w_rt_val[7:0];
         end
         if (w_sel_disp) begin
            r_disp <= w_rt_val[15:0];
         end
      end
   end

   assign led = r_led;

`ifdef SEG_DECODE_EN
   // Hex digit to active-low {g,f,e,d,c,b,a}
   function automatic logic [6:0] seg_hex(input logic [3:0] nib);
      case (nib)
         4'h0:    seg_hex = 7'b1000000;
         4'h1:    seg_hex = 7'b1111001;
         4'h2:    seg_hex = 7'b0100100;
         4'h3:    seg_hex = 7'b0110000;
         4'h4:    seg_hex = 7'b0011001;
         4'h5:    seg_hex = 7'b0010010;
         4'h6:    seg_hex = 7'b0000010;
         4'h7:    seg_hex = 7'b1111000;
         4'h8:    seg_hex = 7'b0000000;
         4'h9:    seg_hex = 7'b0010000;
         4'hA:    seg_hex = 7'b0001000;
         4'hB:    seg_hex = 7'b0000011;
         4'hC:    seg_hex = 7'b1000110;
         4'hD:    seg_hex = 7'b0100001;
         4'hE:    seg_hex = 7'b0000110;
         4'hF:    seg_hex = 7'b0001110;
         default: seg_hex = 7'b1111111;
      endcase
   endfunction

   assign digi_out1 = seg_hex(r_disp[3:0]);
   assign digi_out2 = seg_hex(r_disp[7:4]);
   assign digi_out3 = seg_hex(r_disp[11:8]);
   assign digi_out4 = seg_hex(r_disp[15:12]);
`else
   assign digi_out1 = 7'h7F;
   assign digi_out2 = 7'h7F;
   assign digi_out3 = 7'h7F;
   assign digi_out4 = 7'h7F;
`endif

endmodule

// File: tb/tb_sc_mips_core.sv
module tb_sc_mips_core;

   // Instruction encoders for the alternate ROM image
   function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
      return {6'h00, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
      return {op, tgt};
   endfunction

   // Alternate program: ALU, branches, jal/jr, RAM, unmapped load, $0, NOPs
   function automatic logic [64*32-1:0] alt_image();
      logic [64*32-1:0] img;
      img = '0;
      img[0*32  +: 32] = enc_i(6'h0F, 5'd0,  5'd8,  16'h4000);  // lui  $8,0x4000
      img[1*32  +: 32] = enc_i(6'h09, 5'd0,  5'd1,  16'h0005);  // addiu $1,$0,5
      img[2*32  +: 32] = enc_i(6'h09, 5'd0,  5'd2,  16'hFFFD);  // addiu $2,$0,-3
      img[3*32  +: 32] = enc_r(5'd1,  5'd2,  5'd3,  5'd0, 6'h23);  // subu $3,$1,$2 = 8
      img[4*32  +: 32] = enc_i(6'h2B, 5'd8,  5'd3,  16'h000C);  // sw $3 -> LED
      img[5*32  +: 32] = enc_r(5'd2,  5'd1,  5'd4,  5'd0, 6'h2A);  // slt $4,$2,$1 = 1
      img[6*32  +: 32] = enc_r(5'd1,  5'd2,  5'd5,  5'd0, 6'h2A);  // slt $5,$1,$2 = 0
      img[7*32  +: 32] = enc_r(5'd0,  5'd4,  5'd7,  5'd4, 6'h00);  // sll $7,$4,4
      img[8*32  +: 32] = enc_r(5'd7,  5'd5,  5'd6,  5'd0, 6'h21);  // addu $6,$7,$5
      img[9*32  +: 32] = enc_i(6'h2B, 5'd8,  5'd6,  16'h000C);  // sw $6 -> LED
      img[10*32 +: 32] = enc_i(6'h04, 5'd1,  5'd2,  16'h0001);  // beq (not taken)
      img[11*32 +: 32] = enc_i(6'h09, 5'd0,  5'd9,  16'h0021);  // addiu $9,$0,0x21
      img[12*32 +: 32] = enc_i(6'h05, 5'd1,  5'd2,  16'h0001);  // bne (taken)
      img[13*32 +: 32] = enc_i(6'h09, 5'd0,  5'd9,  16'h007F);  // skipped
      img[14*32 +: 32] = enc_i(6'h2B, 5'd8,  5'd9,  16'h000C);  // sw $9 -> LED
      img[15*32 +: 32] = enc_j(6'h03, 26'd24);                  // jal 24
      img[16*32 +: 32] = enc_i(6'h2B, 5'd8,  5'd31, 16'h000C);  // sw $31 -> LED
      img[17*32 +: 32] = enc_j(6'h02, 26'd27);                  // j 27
      img[24*32 +: 32] = enc_i(6'h09, 5'd0,  5'd10, 16'h0033);  // addiu $10,$0,0x33
      img[25*32 +: 32] = enc_r(5'd31, 5'd0,  5'd0,  5'd0, 6'h08);  // jr $31
      img[27*32 +: 32] = enc_i(6'h0C, 5'd2,  5'd11, 16'h00F0);  // andi -> 0xF0
      img[28*32 +: 32] = enc_i(6'h0D, 5'd11, 5'd12, 16'h000A);  // ori  -> 0xFA
      img[29*32 +: 32] = enc_r(5'd12, 5'd10, 5'd13, 5'd0, 6'h24);  // and -> 0x32
      img[30*32 +: 32] = enc_i(6'h0D, 5'd0,  5'd14, 16'h8000);  // ori zero-ext
      img[31*32 +: 32] = enc_r(5'd14, 5'd0,  5'd15, 5'd0, 6'h2A);  // slt -> 0
      img[32*32 +: 32] = enc_r(5'd13, 5'd15, 5'd13, 5'd0, 6'h21);  // addu
      img[33*32 +: 32] = enc_i(6'h2B, 5'd0,  5'd13, 16'h0010);  // sw RAM[0x10]
      img[34*32 +: 32] = enc_i(6'h2B, 5'd0,  5'd3,  16'h0014);  // sw RAM[0x14]
      img[35*32 +: 32] = enc_i(6'h23, 5'd0,  5'd16, 16'h0010);  // lw $16 = 0x32
      img[36*32 +: 32] = enc_i(6'h0F, 5'd0,  5'd17, 16'h8000);  // lui $17,0x8000
      img[37*32 +: 32] = enc_i(6'h09, 5'd0,  5'd18, 16'h0055);  // addiu $18 = 0x55
      img[38*32 +: 32] = enc_i(6'h23, 5'd17, 5'd18, 16'h0000);  // lw unmapped -> 0
      img[39*32 +: 32] = enc_r(5'd16, 5'd18, 5'd16, 5'd0, 6'h21);
      img[40*32 +: 32] = enc_i(6'h09, 5'd0,  5'd0,  16'h0044);  // write $0
      img[41*32 +: 32] = enc_r(5'd16, 5'd0,  5'd16, 5'd0, 6'h21);
      img[42*32 +: 32] = 32'hFD10_FFFF;                         // unknown opcode
      img[43*32 +: 32] = enc_r(5'd16, 5'd16, 5'd16, 5'd0, 6'h27);  // unknown funct
      img[44*32 +: 32] = enc_i(6'h23, 5'd8,  5'd20, 16'h000C);  // lw LED = 0x40
      img[45*32 +: 32] = enc_r(5'd16, 5'd20, 5'd19, 5'd0, 6'h21);  // 0x72
      img[46*32 +: 32] = enc_i(6'h09, 5'd0,  5'd22, 16'h0003);
      img[47*32 +: 32] = enc_i(6'h09, 5'd22, 5'd22, 16'hFFFF);  // loop: $22--
      img[48*32 +: 32] = enc_i(6'h09, 5'd23, 5'd23, 16'h0002);  //       $23+=2
      img[49*32 +: 32] = enc_i(6'h05, 5'd22, 5'd0,  16'hFFFD);  // bne back to 47
      img[50*32 +: 32] = enc_r(5'd19, 5'd23, 5'd19, 5'd0, 6'h21);  // 0x78
      img[51*32 +: 32] = enc_i(6'h2B, 5'd8,  5'd19, 16'h000C);  // LED = 0x78
      img[52*32 +: 32] = enc_i(6'h2B, 5'd8,  5'd19, 16'h0014);  // disp = 0x0078
      img[53*32 +: 32] = enc_i(6'h23, 5'd8,  5'd21, 16'h0010);  // lw switch
      img[54*32 +: 32] = enc_i(6'h2B, 5'd8,  5'd21, 16'h000C);  // LED = switch
      img[55*32 +: 32] = enc_i(6'h04, 5'd0,  5'd0,  16'hFFFF);  // halt loop
      return img;
   endfunction

   localparam logic [64*32-1:0] ALT_IMG = alt_image();

`ifdef SEG_DECODE_EN
   localparam logic [6:0] S_0 = 7'b1000000;
   localparam logic [6:0] S_1 = 7'b1111001;
   localparam logic [6:0] S_4 = 7'b0011001;
   localparam logic [6:0] S_7 = 7'b1111000;
   localparam logic [6:0] S_8 = 7'b0000000;
   localparam logic [6:0] S_A = 7'b0001000;
`else
   localparam logic [6:0] S_0 = 7'h7F;
   localparam logic [6:0] S_1 = 7'h7F;
   localparam logic [6:0] S_4 = 7'h7F;
   localparam logic [6:0] S_7 = 7'h7F;
   localparam logic [6:0] S_8 = 7'h7F;
   localparam logic [6:0] S_A = 7'h7F;
`endif

   logic       sysclk;
   logic       Reset_n;
   logic [7:0] sw_a, sw_b;
   logic [7:0] led_a, led_b;
   logic [6:0] da1, da2, da3, da4;
   logic [6:0] db1, db2, db3, db4;

   int n_pass;
   int n_checks;
   int edge_cnt;

   sc_mips_core u_boot (
      .sysclk(sysclk), .Reset_n(Reset_n), .switch(sw_a), .led(led_a),
      .digi_out1(da1), .digi_out2(da2), .digi_out3(da3), .digi_out4(da4)
   );

   sc_mips_core #(.IMEM_INIT(ALT_IMG)) u_alt (
      .sysclk(sysclk), .Reset_n(Reset_n), .switch(sw_b), .led(led_b),
      .digi_out1(db1), .digi_out2(db2), .digi_out3(db3), .digi_out4(db4)
   );

   initial sysclk = 1'b0;
   always #5 sysclk = ~sysclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge sysclk);
      #1;
      edge_cnt++;
   endtask

   task automatic run_to(input int n);
      while (edge_cnt < n) tick();
   endtask

   initial begin
      n_pass   = 0;
      n_checks = 0;
      edge_cnt = 0;
      Reset_n  = 1'b0;
      sw_a     = 8'h02;
      sw_b     = 8'h3C;

      #2;
      chk("rst_led_a", {24'h0, led_a}, 32'h00);
      chk("rst_led_b", {24'h0, led_b}, 32'h00);
      chk("rst_dig1",  {25'h0, da1}, {25'h0, S_0});
      chk("rst_dig2",  {25'h0, da2}, {25'h0, S_0});
      chk("rst_dig3",  {25'h0, da3}, {25'h0, S_0});
      chk("rst_dig4",  {25'h0, da4}, {25'h0, S_0});
      tick();
      tick();
      chk("rst_hold_led_a", {24'h0, led_a}, 32'h00);

      @(negedge sysclk);
      Reset_n  = 1'b1;
      edge_cnt = 0;

      // Boot loop with switch = 0x02
      run_to(2);  chk("boot_led_e2", {24'h0, led_a}, 32'h00);
      run_to(3);  chk("boot_led_e3", {24'h0, led_a}, 32'h02);
      run_to(4);  chk("alt_led_e4",  {24'h0, led_b}, 32'h00);
      run_to(5);
      chk("boot_dig1_0004", {25'h0, da1}, {25'h0, S_4});
      chk("boot_dig2_0004", {25'h0, da2}, {25'h0, S_0});
      chk("boot_dig3_0004", {25'h0, da3}, {25'h0, S_0});
      chk("boot_dig4_0004", {25'h0, da4}, {25'h0, S_0});
      chk("alt_subu", {24'h0, led_b}, 32'h08);

      // Change switches while the loop runs
      sw_a = 8'hA5;
      run_to(7);  chk("boot_led_e7", {24'h0, led_a}, 32'h02);
      run_to(8);  chk("boot_led_a5", {24'h0, led_a}, 32'hA5);
      run_to(10);
      chk("boot_dig1_014a", {25'h0, da1}, {25'h0, S_A});
      chk("boot_dig2_014a", {25'h0, da2}, {25'h0, S_4});
      chk("boot_dig3_014a", {25'h0, da3}, {25'h0, S_1});
      chk("boot_dig4_014a", {25'h0, da4}, {25'h0, S_0});
      chk("alt_slt", {24'h0, led_b}, 32'h10);

      // Alternate image results
      run_to(14); chk("alt_branches", {24'h0, led_b}, 32'h21);
      run_to(18); chk("alt_jal_ra",   {24'h0, led_b}, 32'h40);
      run_to(49); chk("alt_led_hold", {24'h0, led_b}, 32'h40);
      run_to(50); chk("alt_mem_sum",  {24'h0, led_b}, 32'h78);
      run_to(51);
      chk("alt_dig1_0078", {25'h0, db1}, {25'h0, S_8});
      chk("alt_dig2_0078", {25'h0, db2}, {25'h0, S_7});
      chk("alt_dig3_0078", {25'h0, db3}, {25'h0, S_0});
      chk("alt_dig4_0078", {25'h0, db4}, {25'h0, S_0});
      run_to(53); chk("alt_switch_rd", {24'h0, led_b}, 32'h3C);
      run_to(63); chk("alt_halt",      {24'h0, led_b}, 32'h3C);

      // Asynchronous reset mid-program clears state without a clock edge
      Reset_n = 1'b0;
      #1;
      chk("midrst_led_a", {24'h0, led_a}, 32'h00);
      chk("midrst_led_b", {24'h0, led_b}, 32'h00);
      chk("midrst_dig_a", {25'h0, da1}, {25'h0, S_0});
      chk("midrst_dig_b", {25'h0, db1}, {25'h0, S_0});
      @(negedge sysclk);
      Reset_n  = 1'b1;
      edge_cnt = 0;
      run_to(2);  chk("rerun_led_e2", {24'h0, led_a}, 32'h00);
      run_to(3);  chk("rerun_led_e3", {24'h0, led_a}, 32'hA5);
      run_to(5);  chk("rerun_alt_e5", {24'h0, led_b}, 32'h08);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
